// File: rtl/branch_pkg.sv
// Shared types for the branch redirect controller: FSM states, BTB entry layout
// and 2-bit BHT counter encoding with its saturating update.
package branch_pkg;

  localparam int BTB_IDX_W = 6;
  localparam int BTB_TAG_W = 8;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [29:0]          target;
  } btb_entry_t;

  localparam logic [1:0] BHT_STRONG_NT = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] BHT_WEAK_T    = 2'b10;
  localparam logic [1:0] BHT_STRONG_T  = 2'b11;

  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != BHT_STRONG_T) nxt = cur + 2'b01;
    else if (!taken && cur != BHT_STRONG_NT) nxt = cur - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/btb_bht_table.sv
// Direct-mapped BTB + BHT storage: one combinational read port, one
// read-modify-write update port and an init clear port (clear wins).
module btb_bht_table
  import branch_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W
) (
  input  logic             clk,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  output logic [1:0]       rd_bht,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  btb_entry_t       upd_entry
);

  localparam int DEPTH = 1 << IDX_W;

  btb_entry_t btb [DEPTH];
  logic [1:0] bht [DEPTH];

  assign rd_entry = btb[rd_idx];
  assign rd_bht   = bht[rd_idx];

  // The BTB is only rewritten on taken resolutions; not-taken only moves the counter.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      btb[clr_idx] <= '0;
      bht[clr_idx] <= BHT_WEAK_NT;
    end else if (upd_en) begin
      bht[upd_idx] <= bht_next(bht[upd_idx], upd_taken);
      if (upd_taken) btb[upd_idx] <= upd_entry;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end PC sequencer with BTB/BHT prediction and mispredict flush/redirect.
// Optional BRANCH_PERF_CNT_EN adds branch and mispredict counters.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          IDX_W    = BTB_IDX_W,
  parameter int          TAG_W    = BTB_TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] if_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_offset,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        flush,
  output logic        busy
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;

  btb_entry_t rd_entry, upd_entry;
  logic [1:0] rd_bht;
  logic       hit, pred_taken;
  logic [31:0] pred_target;
  logic       clr_en, resolve, mispredict;
  logic [31:0] res_sum, res_target, res_seq;

  btb_bht_table #(.IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .clr_en    (clr_en),
    .clr_idx   (cnt_q),
    .rd_idx    (pc_q[IDX_W+1:2]),
    .rd_entry  (rd_entry),
    .rd_bht    (rd_bht),
    .upd_en    (resolve),
    .upd_idx   (res_pc[IDX_W+1:2]),
    .upd_taken (res_taken),
    .upd_entry (upd_entry)
  );

  assign hit         = rd_entry.valid && (rd_entry.tag == pc_q[IDX_W+TAG_W+1:IDX_W+2]);
  assign pred_taken  = (state_q == S_RUN) && hit && rd_bht[1];
  assign pred_target = {rd_entry.target, 2'b00};

  // Targets and fall-through addresses are word aligned before compare and redirect.
  assign res_sum    = res_pc + res_offset;
  assign res_target = {res_sum[31:2], 2'b00};
  assign res_seq    = {res_pc[31:2] + 30'd1, 2'b00};

  assign resolve    = (state_q == S_RUN) && res_valid && res_is_branch;
  assign mispredict = resolve && ((res_taken != res_pred_taken) ||
                                  (res_taken && (res_target != res_pred_target)));

  assign upd_entry.valid  = 1'b1;
  assign upd_entry.tag    = res_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_entry.target = res_target[31:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      pc_q    <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // A mispredict redirect overrides the fetch advance and ignores if_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    clr_en  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (mispredict) begin
          pc_d    = res_taken ? res_target : res_seq;
          state_d = S_FLUSH;
        end else if (if_ready) begin
          pc_d = pred_taken ? pred_target : pc_q + 32'd4;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign if_pc          = pc_q;
  assign if_valid       = (state_q == S_RUN);
  assign if_pred_taken  = pred_taken;
  assign if_pred_target = pred_target;
  assign flush          = mispredict;
  assign busy           = (state_q == S_INIT);

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (resolve) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: expectations are queued with the
// cycle they apply to and compared on the falling clock edge.
module tb_branch_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_ready;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_offset;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        flush;
  logic        busy;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_redirect_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pred_taken   (if_pred_taken),
    .if_pred_target  (if_pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_is_branch   (res_is_branch),
    .res_taken       (res_taken),
    .res_offset      (res_offset),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .flush           (flush),
    .busy            (busy)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  typedef enum int {K_PC, K_VALID, K_BUSY, K_FLUSH, K_PTAKEN, K_PTGT, K_PBR, K_PMP} kind_t;

  typedef struct {
    int          cyc;
    kind_t       kind;
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    logic [31:0] v;
    v = 'x;
    case (k)
      K_PC:     v = if_pc;
      K_VALID:  v = {31'd0, if_valid};
      K_BUSY:   v = {31'd0, busy};
      K_FLUSH:  v = {31'd0, flush};
      K_PTAKEN: v = {31'd0, if_pred_taken};
      K_PTGT:   v = if_pred_target;
`ifdef BRANCH_PERF_CNT_EN
      K_PBR:    v = perf_branches;
      K_PMP:    v = perf_mispredicts;
`endif
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic pushExpected(input kind_t k, input string tag, input logic [31:0] exp,
                              input int ofs = 0);
    sb.push_back('{cyc: cyc + ofs, kind: k, tag: tag, exp: exp});
  endtask

  // Compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput(sb[i].tag, observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic br,
                               input logic tk, input logic [31:0] off,
                               input logic ptk, input logic [31:0] ptgt);
    res_valid       = v;
    res_pc          = pc;
    res_is_branch   = br;
    res_taken       = tk;
    res_offset      = off;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic runInit(input string pfx);
    for (int i = 0; i < 64; i++) begin
      pushExpected(K_BUSY, {pfx, "_busy"}, 32'd1);
      pushExpected(K_VALID, {pfx, "_valid"}, 32'd0);
      pushExpected(K_FLUSH, {pfx, "_flush"}, 32'd0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExpected(K_BUSY, {pfx, "_done_busy"}, 32'd0);
    pushExpected(K_VALID, {pfx, "_done_valid"}, 32'd1);
    pushExpected(K_PC, {pfx, "_done_pc"}, RESET_PC);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    if_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    pushExpected(K_PC, "rst_pc", RESET_PC);
    pushExpected(K_VALID, "rst_valid", 32'd0);
    pushExpected(K_BUSY, "rst_busy", 32'd1);
    pushExpected(K_FLUSH, "rst_flush", 32'd0);
    rst_n = 1'b1;
    // A would-be mispredict during init must be ignored entirely.
    applyStimulus(1, 32'h8000_0010, 1, 1, 32'hFFFF_FFF0, 0, 0);
    if_ready = 1'b1;
    runInit("init");
    step();
    pushExpected(K_PC, "seq_pc4", 32'h8000_0004);
    step();
    pushExpected(K_PC, "seq_pc8", 32'h8000_0008);

    applyStimulus(1, 32'h8000_0010, 1, 1, 32'hFFFF_FFF0, 0, 0);
    pushExpected(K_FLUSH, "mp_taken_flush", 32'd1);
    pushExpected(K_PC, "mp_taken_redirect", RESET_PC, 2);
    step();
    applyStimulus(1, 32'h8000_0100, 1, 1, 32'h40, 0, 0);
    pushExpected(K_VALID, "bubble_valid", 32'd0);
    pushExpected(K_FLUSH, "bubble_ignores_res", 32'd0);
    step();
    applyStimulus(1, 32'h8000_0010, 1, 1, 32'hFFFF_FFF0, 1, RESET_PC);
    pushExpected(K_VALID, "after_bubble_valid", 32'd1);
    pushExpected(K_FLUSH, "correct_pred_noflush", 32'd0);
    step();
    pushExpected(K_PC, "after_bubble_pc4", 32'h8000_0004);
    pushExpected(K_FLUSH, "correct_pred_noflush2", 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExpected(K_PC, "seq_pc8b", 32'h8000_0008);
    step();
    pushExpected(K_PC, "seq_pcCb", 32'h8000_000C);
    step();
    pushExpected(K_PC, "pred_pc", 32'h8000_0010);
    pushExpected(K_PTAKEN, "pred_taken_strong", 32'd1);
    pushExpected(K_PTGT, "pred_target", RESET_PC);
    step();
    pushExpected(K_PC, "pred_followed", RESET_PC);
    pushExpected(K_FLUSH, "pred_no_flush", 32'd0);
    pushExpected(K_PTAKEN, "no_pred_at_0", 32'd0);
    if_ready = 1'b0;
    step();
    pushExpected(K_PC, "hold_no_ready", RESET_PC);
    if_ready = 1'b1;

    applyStimulus(1, 32'h8000_0010, 1, 0, 32'hFFFF_FFF0, 1, RESET_PC);
    pushExpected(K_FLUSH, "mp_nt_flush", 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExpected(K_VALID, "mp_nt_bubble", 32'd0);
    step();
    pushExpected(K_PC, "mp_nt_redirect", 32'h8000_0014);
    applyStimulus(1, 32'h8000_0020, 1, 1, 32'hFFFF_FFF0, 0, 0);
    pushExpected(K_FLUSH, "mp_back_flush", 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    pushExpected(K_PC, "back_at_10", 32'h8000_0010);
    pushExpected(K_PTAKEN, "bht_dec_by_one", 32'd1);
    pushExpected(K_PTGT, "bht_dec_target", RESET_PC);
    step();

    // JALR: right direction, wrong target (pred 0x100, actual 0x200).
    pushExpected(K_PC, "pre_jalr_pc", RESET_PC);
    applyStimulus(1, 32'h8000_0040, 1, 1, 32'h8000_01C0, 1, 32'h0000_0100);
    pushExpected(K_FLUSH, "jalr_tgt_flush", 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExpected(K_VALID, "jalr_bubble", 32'd0);
    step();
    pushExpected(K_PC, "jalr_redirect", 32'h0000_0200);
    applyStimulus(1, 32'h8000_0030, 1, 1, 32'h0000_0013, 0, 0);
    pushExpected(K_FLUSH, "unaligned_flush", 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    pushExpected(K_PC, "unaligned_redirect", 32'h8000_0040);
    pushExpected(K_PTAKEN, "btb_upd_taken", 32'd1);
    pushExpected(K_PTGT, "btb_upd_target", 32'h0000_0200);
    step();
    pushExpected(K_PC, "btb_followed", 32'h0000_0200);
    applyStimulus(1, 32'h0000_0200, 0, 1, 32'd8, 0, 0);
    pushExpected(K_FLUSH, "non_branch_noflush", 32'd0);
    step();
    pushExpected(K_PC, "non_branch_seq", 32'h0000_0204);
    applyStimulus(1, 32'h0000_0204, 1, 1, 32'd8, 0, 0);
    pushExpected(K_FLUSH, "pre_rst_flush", 32'd1);
    step();

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExpected(K_VALID, "flush_state_valid", 32'd0);
`ifdef BRANCH_PERF_CNT_EN
    pushExpected(K_PBR, "perf_branches", 32'd8);
    pushExpected(K_PMP, "perf_mispredicts", 32'd6);
`endif
    rst_n = 1'b0;
    step();
    pushExpected(K_PC, "mid_rst_pc", RESET_PC);
    pushExpected(K_BUSY, "mid_rst_busy", 32'd1);
    pushExpected(K_FLUSH, "mid_rst_flush", 32'd0);
`ifdef BRANCH_PERF_CNT_EN
    pushExpected(K_PBR, "mid_rst_perf_br", 32'd0);
    pushExpected(K_PMP, "mid_rst_perf_mp", 32'd0);
`endif
    rst_n = 1'b1;
    runInit("reinit");
    step();
    pushExpected(K_PC, "reinit_seq_pc4", 32'h8000_0004);
    step();

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
